mem_arbiter: RTL

- Two-client arbiter directly upstream of the backup memory.
- Merges the instruction-cache (client 0) and data-cache (client 1) miss/writeback request streams into the single memory request and write-data channel.
- Tags each request with the client ID and routes each response back to its owner by tag MSB.
- Round-robin grant; the grant is locked for the duration of a write's data phase.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request / write-data / response bundle shared by the cache clients and the backup memory.
// master = side that issues requests; slave = side that accepts them.
interface mem_arbiter_if #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_W     = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [TAG_W-1:0]       req_tag;
  logic                   req_data_valid;
  logic                   req_data_ready;
  logic [DATA_BITS-1:0]   req_data_bits;
  logic [DATA_BITS/8-1:0] req_data_mask;
  logic [1:0]             req_data_offset;
  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;
  logic [TAG_W-1:0]       resp_tag;

  modport master (
    output req_valid, req_rw, req_addr, req_tag,
    output req_data_valid, req_data_bits, req_data_mask, req_data_offset,
    input  req_ready, req_data_ready, resp_valid, resp_data, resp_tag
  );

  // Clients carry no beat offset; only the memory side sees one.
  modport slave (
    input  req_valid, req_rw, req_addr, req_tag,
    input  req_data_valid, req_data_bits, req_data_mask,
    output req_ready, req_data_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of the backup memory. A transfer happens on a
// channel in any cycle where valid and ready are both high; valid never waits on ready.
module mem_arbiter #(
  parameter int ADDR_BITS   = 28,
  parameter int DATA_BITS   = 128,
  parameter int TAG_BITS    = 5,
  parameter int WRITE_BEATS = 1
) (
  input  logic       clk,
  input  logic       reset,
  mem_arbiter_if.slave  c0,
  mem_arbiter_if.slave  c1,
  mem_arbiter_if.master mem,
  output logic       dbg_state,
  output logic       dbg_prio,
  output logic       dbg_owner,
  output logic [1:0] dbg_beat
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WDATA = 1'b1;
  localparam logic [1:0] LAST_BEAT = 2'(WRITE_BEATS - 1);

  logic [0:0] state;
  logic       prio;
  logic       owner;
  logic [1:0] beat;

  logic                   in_idle;
  logic                   in_wdata;
  logic                   grant;
  logic                   gnt_rw;
  logic [ADDR_BITS-1:0]   gnt_addr;
  logic [TAG_BITS-2:0]    gnt_tag;
  logic [DATA_BITS-1:0]   own_bits;
  logic [DATA_BITS/8-1:0] own_mask;
  logic                   own_valid;
  logic                   req_fire;
  logic                   beat_fire;

  assign in_idle  = (state == IDLE);
  assign in_wdata = (state == WDATA);

  // With no contention the requester wins; with both requesting, prio breaks the tie.
  assign grant    = (c0.req_valid & c1.req_valid) ? prio : c1.req_valid;
  assign gnt_rw   = grant ? c1.req_rw   : c0.req_rw;
  assign gnt_addr = grant ? c1.req_addr : c0.req_addr;
  assign gnt_tag  = grant ? c1.req_tag  : c0.req_tag;

  assign mem.req_valid = in_idle & (c0.req_valid | c1.req_valid);
  assign mem.req_rw    = gnt_rw;
  assign mem.req_addr  = gnt_addr;
  assign mem.req_tag   = {grant, gnt_tag};

  assign c0.req_ready = in_idle & ~grant & c0.req_valid & mem.req_ready;
  assign c1.req_ready = in_idle &  grant & c1.req_valid & mem.req_ready;

  assign req_fire = mem.req_valid & mem.req_ready;

  // Write-data channel is only open to the owner of the accepted write.
  assign own_valid = owner ? c1.req_data_valid : c0.req_data_valid;
  assign own_bits  = owner ? c1.req_data_bits  : c0.req_data_bits;
  assign own_mask  = owner ? c1.req_data_mask  : c0.req_data_mask;

  assign mem.req_data_valid  = in_wdata & own_valid;
  assign mem.req_data_bits   = own_bits;
  assign mem.req_data_mask   = own_mask;
  assign mem.req_data_offset = beat;

  assign c0.req_data_ready = in_wdata & ~owner & mem.req_data_ready;
  assign c1.req_data_ready = in_wdata &  owner & mem.req_data_ready;

  assign beat_fire = mem.req_data_valid & mem.req_data_ready;

  // Responses bypass arbitration entirely: the tag MSB names the owner.
  assign c0.resp_valid = mem.resp_valid & ~mem.resp_tag[TAG_BITS-1];
  assign c1.resp_valid = mem.resp_valid &  mem.resp_tag[TAG_BITS-1];
  assign c0.resp_tag   = mem.resp_tag[TAG_BITS-2:0];
  assign c1.resp_tag   = mem.resp_tag[TAG_BITS-2:0];
  assign c0.resp_data  = mem.resp_data;
  assign c1.resp_data  = mem.resp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      beat  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            prio <= ~grant;
            if (gnt_rw) begin
              owner <= grant;
              beat  <= 2'd0;
              state <= WDATA;
            end
          end
        end
        WDATA: begin
          if (beat_fire) begin
            if (beat == LAST_BEAT) begin
              beat  <= 2'd0;
              state <= IDLE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state[0];
  assign dbg_prio  = prio;
  assign dbg_owner = owner;
  assign dbg_beat  = beat;
endmodule
